// File: rtl/board_io_pkg.sv
// Shared board I/O constants: clock rate, debounce window and auto-repeat defaults.
// The repeat defaults are only consumed when BTN_DEBOUNCE_REPEAT_EN is defined.
package board_io_pkg;

  localparam int CLK_HZ                  = 100000000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int HOLD_CYCLES_DEFAULT     = 50000000;
  localparam int REPEAT_CYCLES_DEFAULT   = 10000000;

endpackage

// File: rtl/debounce_ch.sv
// One input channel: two-flop synchroniser, stability counter, level and press/release pulses.
// Optional auto-repeat on press is built when BTN_DEBOUNCE_REPEAT_EN is defined.
module debounce_ch
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
`ifdef BTN_DEBOUNCE_REPEAT_EN
  ,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
`endif
) (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic press,
  output logic release_pulse
);

  logic             s1_p0, s2_p1;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             flip, level_nxt, press_nxt, release_nxt;

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int RCNT_W = $clog2(HOLD_CYCLES);
  logic [RCNT_W-1:0] rcnt, rcnt_nxt;
  logic              rep_hit;
`endif

  always_comb begin
    flip        = 1'b0;
    level_nxt   = level;
    cnt_nxt     = '0;
    if (s2_p1 != level) begin
      if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        flip      = 1'b1;
        level_nxt = ~level;
      end else begin
        cnt_nxt   = cnt + CNT_W'(1);
      end
    end
    press_nxt   = flip & ~level;
    release_nxt = flip & level;
`ifdef BTN_DEBOUNCE_REPEAT_EN
    // Reloading to HOLD-REPEAT after a hit makes every later hit REPEAT cycles apart.
    rep_hit  = 1'b0;
    rcnt_nxt = '0;
    if (level && !flip) begin
      if (rcnt == RCNT_W'(HOLD_CYCLES - 1)) begin
        rep_hit  = 1'b1;
        rcnt_nxt = RCNT_W'(HOLD_CYCLES - REPEAT_CYCLES);
      end else begin
        rcnt_nxt = rcnt + RCNT_W'(1);
      end
    end
    press_nxt = press_nxt | rep_hit;
`endif
  end

  // stage p0/p1: synchroniser; then level, counter and pulse registers
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      s1_p0         <= 1'b0;
      s2_p1         <= 1'b0;
      level         <= 1'b0;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1_p0         <= raw_in;
      s2_p1         <= s1_p0;
      level         <= level_nxt;
      cnt           <= cnt_nxt;
      press         <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

`ifdef BTN_DEBOUNCE_REPEAT_EN
  always_ff @(posedge CLK100MHZ) begin
    if (reset) rcnt <= '0;
    else       rcnt <= rcnt_nxt;
  end
`endif

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button/switch conditioner: NUM_CH independent debounce_ch instances.
// Define BTN_DEBOUNCE_REPEAT_EN to add auto-repeat on press.
module btn_debounce
  import board_io_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
`ifdef BTN_DEBOUNCE_REPEAT_EN
  ,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
`endif
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press,
  output logic [NUM_CH-1:0] release_pulse
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
`ifdef BTN_DEBOUNCE_REPEAT_EN
      ,
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
    ) u_ch (
      .CLK100MHZ     (CLK100MHZ),
      .reset         (reset),
      .raw_in        (raw_in[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule
